// File: rtl/digit_serial_arith_unit_if.sv
// Handshake and operand/result bundle for digit_serial_arith_unit.
//   master: drives start, a, b, sel, cin, acc_en; observes busy, done, d,
//           cout, ovf, zero.
//   slave : the arithmetic unit itself (opposite directions).
interface digit_serial_arith_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic             cin;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, sel, cin, acc_en,
    input  busy, done, d, cout, ovf, zero
  );

  modport slave (
    input  start, a, b, sel, cin, acc_en,
    output busy, done, d, cout, ovf, zero
  );
endinterface

// File: rtl/digit_serial_arith_unit.sv
// Digit-serial adder computing d = A + Y + cin, Y in {b, ~b, 0, all-ones},
// DIGIT bits per clock, LSB digit first. A is either a or the current d
// (accumulate mode). Results and flags update only on the completion edge.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of digit_serial_arith_unit_if (start/busy/done
//           handshake, operands, result and carry/overflow/zero flags)
module digit_serial_arith_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  digit_serial_arith_unit_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;      // shadow result, never visible on d
  logic [1:0]       sel_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] y_dig;
  logic [DIGIT-1:0] sum_dig;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // Current digit datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    y_dig    = '0;
    a_dig    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    b_dig    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    case (sel_q)
      2'b00:   y_dig = b_dig;
      2'b01:   y_dig = ~b_dig;
      2'b10:   y_dig = '0;
      default: y_dig = '1;
    endcase
    {c_out, sum_dig} = {1'b0, a_dig} + {1'b0, y_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit recovered from its sum bit; this
    // also covers DIGIT=1, where it is simply the incoming carry.
    c_msb    = a_dig[DIGIT-1] ^ y_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
    res_next = res_q;
    res_next[int'(cnt_q) * DIGIT +: DIGIT] = sum_dig;
    last     = (cnt_q == CW'(N - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and shadow registers are cleared too, not just the
      // control state, so the block restarts from a fully defined datapath.
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.acc_en ? bus.d : bus.a;
            b_q      <= bus.b;
            sel_q    <= bus.sel;
            carry_q  <= bus.cin;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= c_out;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            bus.d    <= res_next;
            bus.cout <= c_out;
            bus.ovf  <= c_out ^ c_msb;
            bus.zero <= (res_next == '0);
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_arith_unit.sv
// Directed and randomised checks of digit_serial_arith_unit in three
// configurations: 16/4 (main), 8/8 (single cycle) and 32/1 (bit serial).
module tb_digit_serial_arith_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [1:0]  s_sel = '0;
  logic        s_cin = 1'b0;
  logic        s_acc = 1'b0;
  logic        st16 = 1'b0;
  logic        st8 = 1'b0;
  logic        st32 = 1'b0;

  digit_serial_arith_unit_if #(.WIDTH(16)) if16 ();
  digit_serial_arith_unit_if #(.WIDTH(8))  if8 ();
  digit_serial_arith_unit_if #(.WIDTH(32)) if32 ();

  assign if16.start = st16;       assign if8.start = st8;        assign if32.start = st32;
  assign if16.a = s_a[15:0];      assign if8.a = s_a[7:0];       assign if32.a = s_a;
  assign if16.b = s_b[15:0];      assign if8.b = s_b[7:0];       assign if32.b = s_b;
  assign if16.sel = s_sel;        assign if8.sel = s_sel;        assign if32.sel = s_sel;
  assign if16.cin = s_cin;        assign if8.cin = s_cin;        assign if32.cin = s_cin;
  assign if16.acc_en = s_acc;     assign if8.acc_en = s_acc;     assign if32.acc_en = s_acc;

  digit_serial_arith_unit #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  digit_serial_arith_unit #(.WIDTH(8),  .DIGIT(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  digit_serial_arith_unit #(.WIDTH(32), .DIGIT(1)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  // Behavioural reference: whole-word add, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] sel, input logic cin);
    res_t        r;
    logic [31:0] mask;
    logic [31:0] y;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    case (sel)
      2'b00:   y = b;
      2'b01:   y = ~b;
      2'b10:   y = 32'h0;
      default: y = 32'hFFFF_FFFF;
    endcase
    y      = y & mask;
    a      = a & mask;
    full   = {1'b0, a} + {1'b0, y} + {32'h0, cin};
    r.d    = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (a[w-1] == y[w-1]) && (r.d[w-1] != a[w-1]);
    r.zero = (r.d == 32'h0);
    return r;
  endfunction

  logic [31:0] prev16 = '0;
  logic [31:0] prev8 = '0;
  logic [31:0] prev32 = '0;
  logic [31:0] last_d16;
  logic        last_c16, last_o16, last_z16;

  // Waits (bounded) for done on the 16-bit unit; lat = edges after E0, -1 on timeout.
  task automatic wait_done16(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if16.done) begin
        lat = k;
        return;
      end
    end
  endtask

  // One operation on all three units in parallel, checked against the model.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic cin, input logic acc);
    res_t        e[3];
    int          lat[3];
    bit          seen[3];
    logic [31:0] gd[3];
    logic        gc[3], go[3], gz[3];
    int          exp_lat[3];
    e[0] = model(16, acc ? prev16 : a, b, sel, cin);
    e[1] = model(8,  acc ? prev8  : a, b, sel, cin);
    e[2] = model(32, acc ? prev32 : a, b, sel, cin);
    exp_lat[0] = 4; exp_lat[1] = 1; exp_lat[2] = 32;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; seen[i] = 1'b0; gd[i] = '0; gc[i] = 1'b0; go[i] = 1'b0; gz[i] = 1'b0;
    end
    @(negedge clk);
    s_a = a; s_b = b; s_sel = sel; s_cin = cin; s_acc = acc;
    st16 = 1'b1; st8 = 1'b1; st32 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0; st8 = 1'b0; st32 = 1'b0;
    check("busy16_after_start", {31'h0, if16.busy}, 32'h1);
    for (int k = 1; k <= 40 && !(seen[0] && seen[1] && seen[2]); k++) begin
      @(posedge clk); #1;
      if (!seen[0] && if16.done) begin
        seen[0] = 1'b1; lat[0] = k; gd[0] = {16'h0, if16.d};
        gc[0] = if16.cout; go[0] = if16.ovf; gz[0] = if16.zero;
        check("busy16_in_done", {31'h0, if16.busy}, 32'h0);
      end
      if (!seen[1] && if8.done) begin
        seen[1] = 1'b1; lat[1] = k; gd[1] = {24'h0, if8.d};
        gc[1] = if8.cout; go[1] = if8.ovf; gz[1] = if8.zero;
      end
      if (!seen[2] && if32.done) begin
        seen[2] = 1'b1; lat[2] = k; gd[2] = if32.d;
        gc[2] = if32.cout; go[2] = if32.ovf; gz[2] = if32.zero;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("latency", lat[i], exp_lat[i]);
      check("d", gd[i], e[i].d);
      check("cout", {31'h0, gc[i]}, {31'h0, e[i].cout});
      check("ovf", {31'h0, go[i]}, {31'h0, e[i].ovf});
      check("zero", {31'h0, gz[i]}, {31'h0, e[i].zero});
    end
    prev16 = e[0].d; prev8 = e[1].d; prev32 = e[2].d;
    last_d16 = gd[0]; last_c16 = gc[0]; last_o16 = go[0]; last_z16 = gz[0];
  endtask

  initial begin
    int lat;
    int dones;

    // Reset state.
    #12;
    check("rst_busy", {31'h0, if16.busy}, 32'h0);
    check("rst_done", {31'h0, if16.done}, 32'h0);
    check("rst_d", {16'h0, if16.d}, 32'h0);
    check("rst_flags", {29'h0, if16.cout, if16.ovf, if16.zero}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Add.
    run_op(32'h1234, 32'h0FFF, 2'b00, 1'b0, 1'b0);
    check("add_d", last_d16, 32'h2233);
    check("add_flags", {29'h0, last_c16, last_o16, last_z16}, 32'h0);

    // Subtract both ways.
    run_op(32'h0005, 32'h0007, 2'b01, 1'b1, 1'b0);
    check("sub_neg_d", last_d16, 32'hFFFE);
    check("sub_neg_cout", {31'h0, last_c16}, 32'h0);
    check("sub_neg_ovf", {31'h0, last_o16}, 32'h0);
    run_op(32'h0007, 32'h0005, 2'b01, 1'b1, 1'b0);
    check("sub_pos_d", last_d16, 32'h0002);
    check("sub_pos_cout", {31'h0, last_c16}, 32'h1);

    // Signed overflow.
    run_op(32'h7FFF, 32'h0001, 2'b00, 1'b0, 1'b0);
    check("ovf_d", last_d16, 32'h8000);
    check("ovf_ovf", {31'h0, last_o16}, 32'h1);
    check("ovf_cout", {31'h0, last_c16}, 32'h0);

    // Decrement, then back-to-back accumulate started in the done cycle.
    @(negedge clk);
    s_a = 32'h0; s_b = 32'h0; s_sel = 2'b11; s_cin = 1'b0; s_acc = 1'b0; st16 = 1'b1;
    @(posedge clk); #1; st16 = 1'b0;
    wait_done16(lat);
    check("dec_latency", lat, 4);
    check("dec_d", {16'h0, if16.d}, 32'hFFFF);
    check("dec_cout", {31'h0, if16.cout}, 32'h0);
    s_sel = 2'b10; s_cin = 1'b1; s_acc = 1'b1; st16 = 1'b1;
    @(posedge clk); #1; st16 = 1'b0;
    check("b2b_busy", {31'h0, if16.busy}, 32'h1);
    check("b2b_done_one_cycle", {31'h0, if16.done}, 32'h0);
    check("b2b_d_holds", {16'h0, if16.d}, 32'hFFFF);
    wait_done16(lat);
    check("acc_latency", lat, 4);
    check("acc_d", {16'h0, if16.d}, 32'h0000);
    check("acc_flags", {29'h0, if16.cout, if16.ovf, if16.zero}, 32'h5);
    @(posedge clk); #1;
    check("acc_done_one_cycle", {31'h0, if16.done}, 32'h0);
    prev16 = 32'h0;

    // start held high through RUN with a changing: one done, captured operands.
    @(negedge clk);
    s_a = 32'h1111; s_b = 32'h2222; s_sel = 2'b00; s_cin = 1'b0; s_acc = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      s_a = $urandom;
      @(posedge clk); #1;
      if (if16.done) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          check("held_d", {16'h0, if16.d}, 32'h3333);
        end
        st16 = 1'b0;
      end
    end
    check("held_latency", lat, 4);
    check("held_dones", dones, 1);
    prev16 = 32'h3333;

    // Reset during RUN: immediate abort, no done afterwards.
    @(negedge clk);
    s_a = 32'h0001; s_b = 32'h0001; st16 = 1'b1;
    @(posedge clk); #1; st16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, if16.busy}, 32'h0);
    check("abort_d", {16'h0, if16.d}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (if16.done) dones++;
    end
    check("abort_no_done", dones, 0);
    prev16 = '0; prev8 = '0; prev32 = '0;

    // Random sweep over every sel/cin/acc_en combination, all three widths.
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 6; r++)
        run_op($urandom, $urandom, c[1:0], c[2], c[3]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
